// File: rtl/wb_lfsr_seq_master.sv
// Wishbone initiator: seeds the LFSR peripheral (4 byte writes, load, run), then reads N bits into o_word.
// Two cycles per transaction when not stalled, stb held while stalled; optional ack timeout via WB_LFSR_SEQ_MASTER_TIMEOUT_EN.
module wb_lfsr_seq_master #(
  parameter logic [7:0] CTRL_LOAD = 8'h02,
  parameter logic [7:0] CTRL_RUN  = 8'h00
`ifdef WB_LFSR_SEQ_MASTER_TIMEOUT_EN
  , parameter int unsigned TIMEOUT = 16
`endif
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_start,
  input  logic [31:0] i_seed,
  input  logic [5:0]  i_nbits,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_error,
  output logic [31:0] o_word,
  output logic        o_wb_cyc,
  output logic        o_wb_stb,
  output logic        o_wb_we,
  output logic [2:0]  o_wb_addr,
  output logic [7:0]  o_wb_data,
  input  logic        i_wb_stall,
  input  logic        i_wb_ack,
  input  logic        i_wb_data
);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, DONE, ERR} state_t;

  state_t      state, state_nxt;
  logic [5:0]  step;
  logic [5:0]  nbits;
  logic [5:0]  last_step;
  logic [31:0] seed;
  logic        is_read;

  assign is_read   = (step >= 6'd6);
  assign last_step = nbits + 6'd5;

`ifdef WB_LFSR_SEQ_MASTER_TIMEOUT_EN
  logic [15:0] wait_cnt;
  logic        timed_out;

  // Counter is zero on the first WAIT cycle, so ERR lands TIMEOUT cycles after WAIT entry.
  assign timed_out = (state == WAIT) && !i_wb_ack && (wait_cnt == 16'(TIMEOUT - 1));

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n)          wait_cnt <= '0;
    else if (state != WAIT)  wait_cnt <= '0;
    else                     wait_cnt <= wait_cnt + 16'd1;
  end
`endif

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) state <= IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (i_start) state_nxt = ISSUE;
      ISSUE: if (!i_wb_stall) state_nxt = WAIT;
      WAIT: begin
        if (i_wb_ack) state_nxt = (step == last_step) ? DONE : ISSUE;
`ifdef WB_LFSR_SEQ_MASTER_TIMEOUT_EN
        else if (timed_out) state_nxt = ERR;
`endif
      end
      DONE:    state_nxt = IDLE;
      ERR:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      step   <= '0;
      nbits  <= '0;
      seed   <= '0;
      o_word <= '0;
    end else if (state == IDLE && i_start) begin
      seed   <= i_seed;
      nbits  <= (i_nbits == 6'd0 || i_nbits > 6'd32) ? 6'd32 : i_nbits;
      step   <= '0;
      o_word <= '0;
    end else if (state == WAIT && i_wb_ack) begin
      step <= step + 6'd1;
      if (is_read) o_word <= {o_word[30:0], i_wb_data};
    end else if (state == DONE || state == ERR) begin
      step <= '0;
    end
  end

  always_comb begin
    o_wb_cyc  = (state == ISSUE) || (state == WAIT);
    o_wb_stb  = (state == ISSUE);
    o_wb_we   = 1'b0;
    o_wb_addr = 3'd0;
    o_wb_data = 8'h00;
    o_busy    = (state == ISSUE) || (state == WAIT);
    o_done    = (state == DONE);
`ifdef WB_LFSR_SEQ_MASTER_TIMEOUT_EN
    o_error   = (state == ERR);
`else
    o_error   = 1'b0;
`endif
    // Payload only driven while strobing; reads use address 0 with zero data.
    if (state == ISSUE) begin
      if (step < 6'd4) begin
        o_wb_we   = 1'b1;
        o_wb_addr = step[2:0];
        o_wb_data = seed[8*step[1:0] +: 8];
      end else if (step == 6'd4) begin
        o_wb_we   = 1'b1;
        o_wb_addr = 3'd4;
        o_wb_data = CTRL_LOAD;
      end else if (step == 6'd5) begin
        o_wb_we   = 1'b1;
        o_wb_addr = 3'd4;
        o_wb_data = CTRL_RUN;
      end
    end
  end

endmodule

// File: tb/tb_wb_lfsr_seq_master.sv
// Self-checking bench: behavioural LFSR peripheral on the bus plus a word-level reference model.
module tb_wb_lfsr_seq_master;
  logic        clk = 1'b0;
  logic        i_reset_n = 1'b1;
  logic        i_start = 1'b0;
  logic [31:0] i_seed = '0;
  logic [5:0]  i_nbits = '0;
  logic        o_busy, o_done, o_error;
  logic [31:0] o_word;
  logic        o_wb_cyc, o_wb_stb, o_wb_we;
  logic [2:0]  o_wb_addr;
  logic [7:0]  o_wb_data;
  logic        i_wb_stall = 1'b0, i_wb_ack = 1'b0, i_wb_data = 1'b0;

  int n_checks = 0, n_pass = 0, n_fail = 0;

  logic [31:0] sl_seed = '0, sl_lfsr = '0;
  logic        pend = 1'b0, pend_we = 1'b0;
  logic [2:0]  pend_addr = '0;
  logic [7:0]  pend_data = '0;
  logic [11:0] held = '0;
  logic        have_held = 1'b0, hold_err = 1'b0;
  int          txn_idx = 0, rd_cnt = 0, stall_txn = -1, stall_left = 0, stall_cycles = 0, hang_read = 0;
  logic [11:0] txn_log[$];

  always #5 clk = ~clk;

  wb_lfsr_seq_master dut (
    .i_clk(clk), .i_reset_n(i_reset_n), .i_start(i_start), .i_seed(i_seed), .i_nbits(i_nbits),
    .o_busy(o_busy), .o_done(o_done), .o_error(o_error), .o_word(o_word),
    .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we), .o_wb_addr(o_wb_addr),
    .o_wb_data(o_wb_data), .i_wb_stall(i_wb_stall), .i_wb_ack(i_wb_ack), .i_wb_data(i_wb_data)
  );

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? 32'hA300_0000 : 32'h0);
  endfunction

  // First generated bit ends up at position n-1, last at bit 0.
  function automatic logic [31:0] model_word(input logic [31:0] seed, input int n);
    logic [31:0] s = seed;
    logic [31:0] w = '0;
    for (int i = 0; i < n; i++) begin
      w = {w[30:0], s[0]};
      s = lfsr_step(s);
    end
    return w;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Peripheral model: acks the cycle after accept, optional stall on one transaction, optional missing ack.
  always @(negedge clk) begin
    if (!i_reset_n) begin
      pend = 1'b0; i_wb_ack = 1'b0; i_wb_stall = 1'b0; i_wb_data = 1'b0; have_held = 1'b0;
    end else begin
      i_wb_ack = 1'b0; i_wb_data = 1'b0; i_wb_stall = 1'b0;
      if (pend) begin
        pend = 1'b0;
        if (pend_we) begin
          if (pend_addr < 3'd4) sl_seed[8*pend_addr +: 8] = pend_data;
          else if (pend_addr == 3'd4 && pend_data[1]) sl_lfsr = sl_seed;
          i_wb_ack = 1'b1;
        end else begin
          rd_cnt++;
          if (rd_cnt != hang_read) begin
            i_wb_data = sl_lfsr[0];
            sl_lfsr   = lfsr_step(sl_lfsr);
            i_wb_ack  = 1'b1;
          end
        end
      end
      if (o_wb_stb) begin
        if (have_held && {o_wb_we, o_wb_addr, o_wb_data} !== held) hold_err = 1'b1;
        if (txn_idx == stall_txn && stall_left > 0) begin
          i_wb_stall = 1'b1;
          stall_left--;
          stall_cycles++;
          held = {o_wb_we, o_wb_addr, o_wb_data};
          have_held = 1'b1;
        end else begin
          have_held = 1'b0;
          pend = 1'b1; pend_we = o_wb_we; pend_addr = o_wb_addr; pend_data = o_wb_data;
          txn_log.push_back({o_wb_we, o_wb_addr, o_wb_we ? o_wb_data : 8'h00});
          txn_idx++;
        end
      end
    end
  end

  task automatic run(input logic [31:0] seed, input logic [5:0] nb, input int stxn, input int slen,
                     input int pulse_at, input int abort_rd, input int hang);
    int neff, done_cyc, err_cyc, mism;
    logic cyc_gap;
    logic [11:0] exp_q[$];
    neff = (nb == 6'd0 || nb > 6'd32) ? 32 : int'(nb);
    txn_idx = 0; rd_cnt = 0; txn_log.delete();
    stall_txn = stxn; stall_left = slen; stall_cycles = 0; hold_err = 1'b0; have_held = 1'b0;
    hang_read = hang;
    done_cyc = -1; err_cyc = -1; cyc_gap = 1'b0;
    @(negedge clk);
    i_seed = seed; i_nbits = nb; i_start = 1'b1;
    @(posedge clk);
    #1 i_start = 1'b0; i_seed = $urandom; i_nbits = 6'($urandom);
    for (int c = 1; c <= 400 && done_cyc < 0 && err_cyc < 0; c++) begin
      @(negedge clk);
      if (c == 1) begin
        check("busy_cycle1", o_busy, 1);
        check("stb_cycle1", o_wb_stb, 1);
      end
      if (c == pulse_at) begin i_seed = ~seed; i_nbits = 6'd3; i_start = 1'b1; end
      if (c == pulse_at + 1) i_start = 1'b0;
      if (o_busy && !o_wb_cyc) cyc_gap = 1'b1;
      if (o_done) done_cyc = c;
      if (o_error) err_cyc = c;
      if (abort_rd > 0 && rd_cnt == abort_rd - 1 && o_wb_stb) begin
        check("word_before_reset", o_word, model_word(seed, abort_rd - 1));
        #2 i_reset_n = 1'b0;
        #1;
        check("rst_cyc", o_wb_cyc, 0);
        check("rst_stb", o_wb_stb, 0);
        check("rst_busy", o_busy, 0);
        check("rst_word", o_word, 0);
        @(negedge clk);
        #1 i_reset_n = 1'b1;
        return;
      end
    end
    if (hang > 0) begin
      check("err_cycle", err_cyc, 2 * (6 + hang - 1) + 2 + 16);
      check("no_done_on_err", done_cyc, -1);
      check("cyc_at_err", o_wb_cyc, 0);
      check("busy_at_err", o_busy, 0);
      check("word_at_err", o_word, model_word(seed, hang - 1));
    end else begin
      check("done_cycle", done_cyc, 2 * (6 + neff) + 1 + slen);
      check("no_error", err_cyc, -1);
      check("busy_at_done", o_busy, 0);
      check("cyc_at_done", o_wb_cyc, 0);
      check("word", o_word, model_word(seed, neff));
      check("read_count", rd_cnt, neff);
      for (int k = 0; k < 4; k++) exp_q.push_back({1'b1, 3'(k), seed[8*k +: 8]});
      exp_q.push_back({1'b1, 3'd4, 8'h02});
      exp_q.push_back({1'b1, 3'd4, 8'h00});
      for (int k = 0; k < neff; k++) exp_q.push_back(12'h000);
      mism = 0;
      for (int k = 0; k < exp_q.size() && k < txn_log.size(); k++)
        if (txn_log[k] !== exp_q[k]) mism++;
      check("txn_count", txn_log.size(), exp_q.size());
      check("txn_payload_mismatches", mism, 0);
      check("cyc_continuous", cyc_gap, 0);
      check("stall_hold", hold_err, 0);
      check("stall_cycles", stall_cycles, slen);
    end
  endtask

  initial begin
    int n, quiet;
    #1 i_reset_n = 1'b0;
    #1;
    check("reset_cyc", o_wb_cyc, 0);
    check("reset_stb", o_wb_stb, 0);
    check("reset_busy", o_busy, 0);
    check("reset_done", o_done, 0);
    check("reset_error", o_error, 0);
    check("reset_word", o_word, 0);
    check("reset_payload", {o_wb_we, o_wb_addr, o_wb_data}, 0);
    repeat (3) @(negedge clk);
    i_reset_n = 1'b1;

    run(32'hDEADBEEF, 6'd8, -1, 0, 0, 0, 0);
    run($urandom, 6'd0, -1, 0, 0, 0, 0);
    run($urandom, 6'd40, -1, 0, 0, 0, 0);
    run(32'hDEADBEEF, 6'd12, 2, 3, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      n = $urandom_range(1, 32);
      run($urandom, 6'(n), $urandom_range(0, 5 + n), $urandom_range(0, 4), 0, 0, 0);
    end

    run($urandom, 6'd8, -1, 0, 10, 0, 0);
    quiet = 0;
    repeat (80) begin
      @(negedge clk);
      if (o_done || o_busy) quiet++;
    end
    check("ignored_start_quiet", quiet, 0);

    run($urandom, 6'd32, -1, 0, 0, 5, 0);
    run($urandom, 6'd5, -1, 0, 0, 0, 0);
`ifdef WB_LFSR_SEQ_MASTER_TIMEOUT_EN
    run($urandom, 6'd8, -1, 0, 0, 0, 2);
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
